// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared decoder frame constants and message FSM state type
// Used by decoder_msg_fsm, msg_word_holdreg and the decoder DRAM WREQ FSM.
package decoder_pkg;

  localparam int BITS_PER_PIX     = 8;
  localparam int FRAME_COLS       = 1280;
  localparam int FRAME_ROWS       = 720;
  localparam int DCT_BLOCK_DIM    = 8;
  localparam int NIBBLES_PER_WORD = 8;
  localparam int MSG_WORD_W       = 4 * NIBBLES_PER_WORD;
  localparam int BLOCKS_PER_FRAME = FRAME_ROWS * FRAME_COLS / (DCT_BLOCK_DIM * DCT_BLOCK_DIM);
  localparam int WORDS_PER_FRAME  = (BLOCKS_PER_FRAME + NIBBLES_PER_WORD - 1) / NIBBLES_PER_WORD;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } dec_msg_state_t;

endpackage

// File: rtl/msg_word_holdreg.sv
// rtl/msg_word_holdreg.sv - single-entry packed-word hold register with outFIFO handshake
// Ports:
//   clk, rst       clock, async active-high reset
//   clr_err        clears the sticky overflow flag (new frame armed)
//   load, load_data a completed word is offered this cycle
//   has_space      outFIFO can accept a word this cycle
//   hold_valid     the register holds an unwritten word
//   wr_en, wdata   outFIFO write strobe and data
//   overflow_err   sticky: a word was offered while the held word was blocked
module msg_word_holdreg
  import decoder_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_err,
  input  logic                  load,
  input  logic [MSG_WORD_W-1:0] load_data,
  input  logic                  has_space,
  output logic                  hold_valid,
  output logic                  wr_en,
  output logic [MSG_WORD_W-1:0] wdata,
  output logic                  overflow_err
);

  logic blocked;

  // Held word cannot leave this cycle; a new word arriving now has nowhere to go.
  assign blocked = hold_valid && !has_space;
  // Combinational from hold_valid so a write can never coincide with has_space=0.
  assign wr_en   = hold_valid && has_space;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid   <= 1'b0;
      wdata        <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (clr_err) begin
        overflow_err <= 1'b0;
      end else if (load && blocked) begin
        overflow_err <= 1'b1;
      end

      // A write and a reload in the same cycle is legal: the old word leaves
      // on wr_en while the new one takes its place.
      if (load && !blocked) begin
        wdata      <= load_data;
        hold_valid <= 1'b1;
      end else if (wr_en) begin
        hold_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/decoder_msg_fsm.sv
// rtl/decoder_msg_fsm.sv - decoder message nibble collector, word packer and frame sequencer
// Ports:
//   decoder_clk, decoder_reset        clock, async active-high reset
//   begin_decoding                    arms a new frame (honoured in IDLE only)
//   nibble_valid, msg_bits_in[3:0]    one extracted nibble per 8x8 block, bit i from channel i
//   msg_outfifo_has_space             outFIFO can accept a word this cycle
//   msg_outfifo_wr_en, _wdata[31:0]   packed word write
//   msg_fsm_ready                     upstream may start another cimg read
//   done_decoding                     one-cycle pulse after the frame's last word is written
//   overflow_err                      sticky: a completed word was dropped
module decoder_msg_fsm
  import decoder_pkg::*;
#(
  parameter int NUM_COLS  = FRAME_COLS,
  parameter int NUM_ROWS  = FRAME_ROWS,
  parameter int BLOCK_DIM = DCT_BLOCK_DIM
) (
  input  logic                  decoder_clk,
  input  logic                  decoder_reset,
  input  logic                  begin_decoding,
  input  logic                  nibble_valid,
  input  logic [3:0]            msg_bits_in,
  input  logic                  msg_outfifo_has_space,
  output logic                  msg_outfifo_wr_en,
  output logic [MSG_WORD_W-1:0] msg_outfifo_wdata,
  output logic                  msg_fsm_ready,
  output logic                  done_decoding,
  output logic                  overflow_err
);

  localparam int FRAME_BLOCKS = NUM_ROWS * NUM_COLS / (BLOCK_DIM * BLOCK_DIM);
  localparam int BLK_W        = (FRAME_BLOCKS > 1) ? $clog2(FRAME_BLOCKS) : 1;

  dec_msg_state_t        state, state_next;
  logic [2:0]            nib_cnt;
  logic [BLK_W-1:0]      blk_cnt;
  logic [MSG_WORD_W-1:0] shift_reg;
  logic [MSG_WORD_W-1:0] packed_word;
  logic                  arm;
  logic                  take_nibble;
  logic                  last_nibble;
  logic                  word_done;
  logic                  hold_valid;

  assign arm         = (state == IDLE) && begin_decoding;
  assign take_nibble = (state == COLLECT) && nibble_valid;
  assign last_nibble = take_nibble && (blk_cnt == BLK_W'(FRAME_BLOCKS - 1));
  assign word_done   = take_nibble && ((nib_cnt == 3'(NIBBLES_PER_WORD - 1)) || last_nibble);

  // Slot nib_cnt of the word; slot 0 is bits [3:0], matching encoder consumption order.
  assign packed_word = shift_reg | (MSG_WORD_W'(msg_bits_in) << {nib_cnt, 2'b00});

  always_ff @(posedge decoder_clk or posedge decoder_reset) begin
    if (decoder_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    done_decoding = 1'b0;
    case (state)
      IDLE: begin
        if (begin_decoding) state_next = COLLECT;
      end
      COLLECT: begin
        if (last_nibble) state_next = DRAIN;
      end
      DRAIN: begin
        // hold_valid drops on the edge that completes the final write,
        // so this pulse lands exactly one cycle after the last wr_en.
        if (!hold_valid) begin
          done_decoding = 1'b1;
          state_next    = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge decoder_clk or posedge decoder_reset) begin
    if (decoder_reset) begin
      nib_cnt   <= '0;
      blk_cnt   <= '0;
      shift_reg <= '0;
    end else if (arm) begin
      nib_cnt   <= '0;
      blk_cnt   <= '0;
      shift_reg <= '0;
    end else if (take_nibble) begin
      // blk_cnt parks on the last block; the FSM leaves COLLECT on that nibble.
      if (!last_nibble) blk_cnt <= blk_cnt + BLK_W'(1);
      if (word_done) begin
        nib_cnt   <= '0;
        shift_reg <= '0;
      end else begin
        nib_cnt   <= nib_cnt + 3'd1;
        shift_reg <= packed_word;
      end
    end
  end

  msg_word_holdreg u_holdreg (
    .clk          (decoder_clk),
    .rst          (decoder_reset),
    .clr_err      (arm),
    .load         (word_done),
    .load_data    (packed_word),
    .has_space    (msg_outfifo_has_space),
    .hold_valid   (hold_valid),
    .wr_en        (msg_outfifo_wr_en),
    .wdata        (msg_outfifo_wdata),
    .overflow_err (overflow_err)
  );

  assign msg_fsm_ready = (state == COLLECT) && !(hold_valid && !msg_outfifo_has_space);

endmodule
